fp16_add_sequencer: RTL and testbench
=====================================

Name: fp16_add_sequencer

Overview:
- Multi-cycle controller and datapath sequencer for IEEE-754 half-precision addition and subtraction.
- Accepts an operand pair over a valid/ready handshake.
- Steps the operation through unpack, iterative alignment, add/subtract, iterative normalisation and rounding.
- Presents the packed 16-bit result over a second valid/ready handshake.
- Sits between the FP operand register file and the result writeback. One operation is in flight at a time.

Parameters:
- MAX_ALIGN, 12, cap on right-shift iterations during alignment. Larger exponent differences zero the smaller mantissa.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer idle and able to accept
- a  input  16  operand A, {sign, exp[4:0], frac[9:0]}
- b  input  16  operand B, same format
- sub  input  1  1 = compute a-b; implemented by inverting b's sign at capture
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  16  packed half-precision result
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=16'h0000, busy=0. All internal registers are cleared.
- Reset asserted mid-operation aborts the operation. No result is produced.
- Capture: in IDLE, in_valid & in_ready captures a, b and sub, then moves to UNPACK.
- in_ready is 1 only in IDLE. in_valid outside IDLE is ignored.
- UNPACK (1 cycle):
  - Special-value path: either exp==31, or inf + (-inf), goes straight to DONE.
    - NaN operand or inf-inf gives 16'h7E00.
    - Otherwise the result is inf carrying that operand's sign.
  - Zero operands (exp==0; subnormals are flushed to zero):
    - One zero operand: the result is the other operand, straight to DONE.
    - Both zero: the result is the sign AND of the two operands.
  - Normal operands: hidden bit is restored, giving 11-bit mantissas extended by 1 guard bit (12 bits).
  - Operands are ordered so the larger magnitude is X. X's sign becomes the result sign.
  - diff = expX - expY. Go to ALIGN.
- ALIGN: shifts mY right by 1 per cycle and decrements diff. Exits when diff==0 or MAX_ALIGN shifts are done. At the cap, mY is forced to 0. diff==0 on entry costs 0 extra cycles.
- ADD (1 cycle):
  - Same effective signs: m = mX + mY, 13 bits.
  - Opposite effective signs: m = mX - mY. X >= Y, so m is never negative.
- NORM:
  - Carry bit set: shift right 1 and exp+1; done in 1 cycle.
  - m==0: result is +0 (16'h0000); go to DONE.
  - Otherwise: shift left 1 per cycle and decrement exp until the hidden bit is 1.
  - exp reaching 0 during NORM: underflow, result is signed zero.
- ROUND (1 cycle):
  - Adds the guard bit to the 11-bit mantissa (round-half-up on magnitude).
  - Mantissa overflow to 2048: shift right and exp+1.
  - exp >= 31 after NORM or ROUND: result is inf with the result sign (16'h7C00 or 16'hFC00).
- DONE: result register loaded; out_valid=1. result stays stable while out_valid & !out_ready.
  - out_valid & out_ready: out_valid falls next cycle; return to IDLE. in_ready=1 that same next cycle.
- Internal exponent is 6 bits signed, so underflow and overflow are detectable without wrap-around.
- Latency from capture to out_valid:
  - 2 cycles on special or zero paths.
  - Otherwise 4 + align_cycles + norm_cycles. Maximum is 4 + 12 + 11 = 27.

Test Plan:
- a=3C00, b=3C00, sub=0 -> result 4000; latency 5 cycles (no align; 1-cycle carry norm).
- a=4000, b=BE00 (2.0 + -1.5) -> result 3800; exactly 1 ALIGN cycle and 2 left-shift NORM cycles are observed.
- a=3C00, b=3C00, sub=1 -> result 0000. a=7BFF, b=7BFF -> result 7C00 (overflow).
- a=7C00, b=FC00 -> 7E00. a=3C00, b=0000 -> 3C00 with out_valid 2 cycles after capture.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stay stable; in_ready stays 0. Release -> one transfer, then in_ready=1.
- Assert rst_n=0 during ALIGN of a=4C00, b=3C00 -> out_valid never rises; in_ready=1 immediately. A fresh 3C00+3C00 afterwards returns 4000.

Source files
------------

// File: rtl/fp16_add_sequencer.sv
// Multi-cycle half-precision add/subtract sequencer.
// One operation in flight; valid/ready on both operand and result sides.
module fp16_add_sequencer #(
    parameter int MAX_ALIGN = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);

    localparam int ACW = $clog2(MAX_ALIGN + 1);

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               esub_q, esub_d;
    logic signed [5:0]  ex_q, ex_d;
    logic [11:0]        mx_q, mx_d;
    logic [11:0]        my_q, my_d;
    logic [4:0]         diff_q, diff_d;
    logic [ACW-1:0]     acnt_q, acnt_d;
    logic [12:0]        m_q, m_d;
    logic [15:0]        res_q, res_d;

    logic [4:0]         ea, eb;
    logic [9:0]         fa, fb;
    logic               sa, sb;
    logic               a_nan, b_nan, a_inf, b_inf, a_big;
    logic [11:0]        rsum;
    logic [10:0]        mant;
    logic               ovf, ofl;
    logic signed [5:0]  ex_r;

    assign ea = a_q[14:10];
    assign eb = b_q[14:10];
    assign fa = a_q[9:0];
    assign fb = b_q[9:0];
    assign sa = a_q[15];
    assign sb = b_q[15];
    assign a_nan = (ea == 5'h1f) && (fa != 10'h0);
    assign b_nan = (eb == 5'h1f) && (fb != 10'h0);
    assign a_inf = (ea == 5'h1f) && (fa == 10'h0);
    assign b_inf = (eb == 5'h1f) && (fb == 10'h0);
    assign a_big = a_q[14:0] >= b_q[14:0];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        esub_d  = esub_q;
        ex_d    = ex_q;
        mx_d    = mx_q;
        my_d    = my_q;
        diff_d  = diff_q;
        acnt_d  = acnt_q;
        m_d     = m_q;
        res_d   = res_q;
        rsum    = {1'b0, m_q[11:1]} + {11'b0, m_q[0]};
        ovf     = rsum[11];
        mant    = ovf ? rsum[11:1] : rsum[10:0];
        ex_r    = ex_q + (ovf ? 6'sd1 : 6'sd0);
        ofl     = (ex_q >= 6'sd31) || (ovf && (ex_q >= 6'sd30));

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = {b[15] ^ sub, b[14:0]};
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (ea == 5'h1f || eb == 5'h1f) begin
                    state_d = DONE;
                    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
                        res_d = 16'h7e00;
                    else if (a_inf)
                        res_d = {sa, 5'h1f, 10'h0};
                    else
                        res_d = {sb, 5'h1f, 10'h0};
                end else if (ea == 5'h0 && eb == 5'h0) begin
                    state_d = DONE;
                    res_d   = {sa & sb, 15'h0};
                end else if (ea == 5'h0) begin
                    state_d = DONE;
                    res_d   = b_q;
                end else if (eb == 5'h0) begin
                    state_d = DONE;
                    res_d   = a_q;
                end else begin
                    esub_d = sa ^ sb;
                    acnt_d = '0;
                    if (a_big) begin
                        sgn_d  = sa;
                        ex_d   = {1'b0, ea};
                        mx_d   = {1'b1, fa, 1'b0};
                        my_d   = {1'b1, fb, 1'b0};
                        diff_d = ea - eb;
                    end else begin
                        sgn_d  = sb;
                        ex_d   = {1'b0, eb};
                        mx_d   = {1'b1, fb, 1'b0};
                        my_d   = {1'b1, fa, 1'b0};
                        diff_d = eb - ea;
                    end
                    state_d = (ea == eb) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                my_d   = my_q >> 1;
                diff_d = diff_q - 5'd1;
                acnt_d = acnt_q + 1'b1;
                if (acnt_q == ACW'(MAX_ALIGN - 1)) begin
                    my_d    = '0;
                    state_d = ADD;
                end else if (diff_q == 5'd1) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (esub_q)
                    m_d = {1'b0, mx_q} - {1'b0, my_q};
                else
                    m_d = {1'b0, mx_q} + {1'b0, my_q};
                state_d = NORM;
            end
            NORM: begin
                if (m_q[12]) begin
                    m_d     = m_q >> 1;
                    ex_d    = ex_q + 6'sd1;
                    state_d = ROUND;
                end else if (m_q == 13'h0) begin
                    res_d   = 16'h0000;
                    state_d = DONE;
                end else if (m_q[11]) begin
                    state_d = ROUND;
                end else begin
                    m_d  = m_q << 1;
                    ex_d = ex_q - 6'sd1;
                    if (ex_q == 6'sd1) begin
                        res_d   = {sgn_q, 15'h0};
                        state_d = DONE;
                    end else if (m_q[10]) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                // guard bit rounds half-up; a carry into 2048 bumps the exponent
                if (ofl)
                    res_d = {sgn_q, 5'h1f, 10'h0};
                else
                    res_d = {sgn_q, ex_r[4:0], mant[9:0]};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            esub_q  <= 1'b0;
            ex_q    <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            diff_q  <= '0;
            acnt_q  <= '0;
            m_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            esub_q  <= esub_d;
            ex_q    <= ex_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            diff_q  <= diff_d;
            acnt_q  <= acnt_d;
            m_q     <= m_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Directed-vector bench for fp16_add_sequencer.
// Checks results, latency, backpressure and mid-operation reset.
module tb_fp16_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        busy;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    fp16_add_sequencer #(.MAX_ALIGN(12)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [15:0] ta, input logic [15:0] tb,
                         input logic ts);
        @(negedge clk);
        a = ta;
        b = tb;
        sub = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts the capture edge as 1
    task automatic wait_out(output int lat);
        lat = 1;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 60);
    endtask

    task automatic op(input string tag, input logic [15:0] ta,
                      input logic [15:0] tb, input logic ts,
                      input logic [15:0] er, input int el);
        int lat;
        start(ta, tb, ts);
        wait_out(lat);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_lat"}, 32'(lat), 32'(el));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int seen;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op("one_plus_one", 16'h3c00, 16'h3c00, 1'b0, 16'h4000, 5);
        op("two_m_1p5",    16'h4000, 16'hbe00, 1'b0, 16'h3800, 7);
        op("one_sub_one",  16'h3c00, 16'h3c00, 1'b1, 16'h0000, 4);
        op("max_ovf",      16'h7bff, 16'h7bff, 1'b0, 16'h7c00, 5);
        op("inf_m_inf",    16'h7c00, 16'hfc00, 1'b0, 16'h7e00, 2);
        op("plus_zero",    16'h3c00, 16'h0000, 1'b0, 16'h3c00, 2);
        op("one_p_half",   16'h3c00, 16'h3800, 1'b0, 16'h3e00, 6);
        op("one_sub_two",  16'h3c00, 16'h4000, 1'b1, 16'hbc00, 6);
        op("diff10",       16'h6400, 16'h3c00, 1'b0, 16'h6401, 15);
        op("rnd_half_up",  16'h6400, 16'h3800, 1'b0, 16'h6401, 16);
        op("align_cap",    16'h7000, 16'h3c00, 1'b0, 16'h7000, 17);
        op("nan_in",       16'h7e01, 16'h3c00, 1'b0, 16'h7e00, 2);
        op("neg_zeros",    16'h8000, 16'h8000, 1'b0, 16'h8000, 2);
        op("mixed_zeros",  16'h8000, 16'h0000, 1'b0, 16'h0000, 2);
        op("inf_plus_one", 16'hfc00, 16'h3c00, 1'b0, 16'hfc00, 2);

        out_ready = 1'b0;
        start(16'h3c00, 16'h3c00, 1'b0);
        wait_out(lat);
        chk("bp_vld", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h4000;
            chk("bp_hold_vld", 32'(out_valid), 32'd1);
            chk("bp_hold_res", 32'(result), 32'h4000);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_vld", 32'(out_valid), 32'd0);
        chk("bp_rel_rdy", 32'(in_ready), 32'd1);

        start(16'h4c00, 16'h3c00, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_rdy", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_vld", 32'(seen), 32'd0);
        op("after_abort", 16'h3c00, 16'h3c00, 1'b0, 16'h4000, 5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
